// File: rtl/cocotb_array_fifo_if.sv
// Bundle of the producer and consumer handshakes of cocotb_array_fifo.
// Both sides use valid/ready: a beat moves on a rising edge where valid and ready are both high;
// valid must not wait on ready, and payload is only meaningful while valid is high.
interface cocotb_array_fifo_if #(
    parameter int WIDTH = 3,
    parameter int ROWS  = 3,
    parameter int COLS  = 3,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_arr [ROWS][COLS];
    logic             in_transpose;
    logic             in_flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_arr [ROWS][COLS];
    logic [CW-1:0]    out_count;

    modport master (
        output in_valid, in_arr, in_transpose, in_flush, out_ready,
        input  in_ready, out_valid, out_arr, out_count
    );

    modport slave (
        input  in_valid, in_arr, in_transpose, in_flush, out_ready,
        output in_ready, out_valid, out_arr, out_count
    );
endinterface

// File: rtl/cocotb_array_fifo.sv
// DEPTH-entry valid/ready FIFO carrying a whole ROWS x COLS array of WIDTH-bit elements per beat.
// Define COCOTB_ARRAY_TRANSPOSE_EN to enable the write-side per-beat transpose (needs ROWS == COLS).
module cocotb_array_fifo #(
    parameter int WIDTH = 3,
    parameter int ROWS  = 3,
    parameter int COLS  = 3,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    cocotb_array_fifo_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q   [DEPTH][ROWS][COLS];
    logic [WIDTH-1:0] mem_d   [DEPTH][ROWS][COLS];
    logic [WIDTH-1:0] wr_beat [ROWS][COLS];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push;
    logic             pop;

`ifdef COCOTB_ARRAY_TRANSPOSE_EN
    generate
        if (ROWS != COLS) begin : g_shape_check
            $error("cocotb_array_fifo: transpose requires ROWS == COLS");
        end
    endgenerate
`else
    logic unused_transpose;
    assign unused_transpose = bus.in_transpose;
`endif

    // No write-through: a pop while full does not open in_ready in the same cycle.
    assign bus.in_ready  = !rst && !bus.in_flush && (count_q < CW'(DEPTH));
    assign bus.out_valid = (count_q != '0);
    assign bus.out_count = count_q;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready && !bus.in_flush;

    // Transposing on the way in keeps the read path a plain mux.
    always_comb begin
        wr_beat = bus.in_arr;
`ifdef COCOTB_ARRAY_TRANSPOSE_EN
        if (bus.in_transpose) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    wr_beat[r][c] = bus.in_arr[c][r];
                end
            end
        end
`endif
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.in_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wr_beat;
                wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                bus.out_arr[r][c] = mem_q[rd_ptr_q][r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        mem_q[e][r][c] <= '0;
                    end
                end
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: tb/tb_cocotb_array_fifo.sv
// Self-checking bench for cocotb_array_fifo: directed scenarios plus random traffic
// compared against a queue-of-beats reference model.
module tb_cocotb_array_fifo;
    localparam int WIDTH = 3;
    localparam int ROWS  = 3;
    localparam int COLS  = 3;
    localparam int DEPTH = 4;
    localparam int FW    = ROWS * COLS * WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [FW-1:0] exp_q[$];

    always #5 clk = ~clk;

    cocotb_array_fifo_if #(.WIDTH(WIDTH), .ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH)) bus ();

    cocotb_array_fifo #(.WIDTH(WIDTH), .ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [FW-1:0] fill_beat(input int v);
        logic [FW-1:0] b;
        for (int i = 0; i < ROWS * COLS; i++) b[i*WIDTH +: WIDTH] = WIDTH'(v);
        return b;
    endfunction

    function automatic logic [FW-1:0] pattern_beat();
        logic [FW-1:0] b;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                b[(r*COLS+c)*WIDTH +: WIDTH] = WIDTH'(3*r + c);
        return b;
    endfunction

    function automatic logic [FW-1:0] random_beat();
        logic [FW-1:0] b;
        for (int i = 0; i < ROWS * COLS; i++) b[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
        return b;
    endfunction

    function automatic logic [FW-1:0] transpose_beat(input logic [FW-1:0] b);
        logic [FW-1:0] t;
        t = b;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                t[(r*COLS+c)*WIDTH +: WIDTH] = b[(c*COLS+r)*WIDTH +: WIDTH];
        return t;
    endfunction

    function automatic logic [FW-1:0] head_flat();
        logic [FW-1:0] b;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                b[(r*COLS+c)*WIDTH +: WIDTH] = bus.out_arr[r][c];
        return b;
    endfunction

    // One clock cycle: apply inputs, compare outputs with the model, then let the edge happen.
    task automatic drive_cycle(input logic r, input logic v, input logic [FW-1:0] beat,
                               input logic tr, input logic fl, input logic ordy);
        logic exp_ready;
        logic do_push;
        logic [FW-1:0] stored;
        rst              = r;
        bus.in_valid     = v;
        bus.in_transpose = tr;
        bus.in_flush     = fl;
        bus.out_ready    = ordy;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                bus.in_arr[i][j] = beat[(i*COLS+j)*WIDTH +: WIDTH];
        #1;
        exp_ready = !r && !fl && (exp_q.size() < DEPTH);
        check("in_ready",  64'(bus.in_ready),  64'(exp_ready));
        check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
        check("out_count", 64'(bus.out_count), 64'(exp_q.size()));
        if (exp_q.size() != 0) check("out_arr", 64'(head_flat()), 64'(exp_q[0]));
        do_push = v && exp_ready;
        stored  = beat;
`ifdef COCOTB_ARRAY_TRANSPOSE_EN
        if (tr) stored = transpose_beat(beat);
`endif
        if (r || fl) begin
            exp_q.delete();
        end else begin
            if (ordy && exp_q.size() != 0) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(stored);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, ordy);
    endtask

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_transpose = 1'b0;
        bus.in_flush     = 1'b0;
        bus.out_ready    = 1'b0;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                bus.in_arr[i][j] = '0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // Reset held with a pending beat: nothing accepted, defaults visible.
        drive_cycle(1'b1, 1'b1, fill_beat(5), 1'b0, 1'b0, 1'b1);
        check("reset_arr_zero", 64'(head_flat()), 64'(0));
        idle(2, 1'b0);
        check("idle_arr_zero", 64'(head_flat()), 64'(0));

        // Single patterned beat, held, then popped.
        drive_cycle(1'b0, 1'b1, pattern_beat(), 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        drive_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);

        // Fill to DEPTH, offer one more, drain, repeat to exercise pointer wrap.
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 1; k <= DEPTH + 1; k++)
                drive_cycle(1'b0, 1'b1, fill_beat(k + pass), 1'b0, 1'b0, 1'b0);
            idle(DEPTH + 1, 1'b1);
        end

        // Streaming with both sides always ready.
        for (int k = 0; k < 20; k++)
            drive_cycle(1'b0, 1'b1, fill_beat(k), 1'b0, 1'b0, 1'b1);
        idle(2, 1'b1);

        // Flush with three entries and a beat offered in the same cycle.
        for (int k = 1; k <= 3; k++)
            drive_cycle(1'b0, 1'b1, fill_beat(k), 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, fill_beat(7), 1'b0, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Transpose flag on one beat, off on the next.
        drive_cycle(1'b0, 1'b1, pattern_beat(), 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, pattern_beat(), 1'b0, 1'b0, 1'b0);
        idle(3, 1'b1);

        // Reset in the middle of traffic.
        for (int k = 1; k <= 3; k++)
            drive_cycle(1'b0, 1'b1, fill_beat(k), 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b1, fill_beat(6), 1'b0, 1'b0, 1'b1);
        idle(1, 1'b1);

        // Random traffic with occasional flush and reset.
        for (int k = 0; k < 400; k++)
            drive_cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), random_beat(),
                        1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0),
                        ($urandom_range(0, 2) != 0));
        idle(DEPTH + 1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
